// File: rtl/pq_pkg.sv
`default_nettype none
// ============================================================================
// Module : pq_pkg
// Brief  : Shared defaults and heap state encoding for the pq queue family.
// Rev    : 1.0  initial release
// ============================================================================
package pq_pkg;
  localparam int PQ_KEY_W  = 16;
  localparam int PQ_VAL_W  = 16;
  localparam int PQ_LEVELS = 4;

  typedef enum logic [1:0] {
    HS_IDLE      = 2'd0,
    HS_SIFT_UP   = 2'd1,
    HS_SIFT_DOWN = 2'd2
  } heap_state_t;
endpackage
`default_nettype wire

// File: rtl/heap_cmp.sv
`default_nettype none
// ============================================================================
// Module : heap_cmp
// Brief  : Strict key comparator; a_better when a must sit above b in the heap.
// Rev    : 1.0  initial release
// ============================================================================
module heap_cmp #(
  parameter int KEY_W     = 16,
  parameter int MAX_FIRST = 0
) (
  input  logic [KEY_W-1:0] a,
  input  logic [KEY_W-1:0] b,
  output logic             a_better
);
  // Strict compare so equal keys never swap.
  generate
    if (MAX_FIRST != 0) begin : g_max
      assign a_better = (a > b);
    end else begin : g_min
      assign a_better = (a < b);
    end
  endgenerate
endmodule
`default_nettype wire

// File: rtl/heap_pq_param.sv
`default_nettype none
// ============================================================================
// Module : heap_pq_param
// Brief  : Parametrised multi-cycle binary-heap priority queue with busy
//          handshake and replace-top. Optional sticky err port: HEAP_PQ_ERR_EN.
// Rev    : 1.0  initial release
// ============================================================================
module heap_pq_param
  import pq_pkg::*;
#(
  parameter int KEY_W     = PQ_KEY_W,
  parameter int VAL_W     = PQ_VAL_W,
  parameter int LEVELS    = PQ_LEVELS,
  parameter int MAX_FIRST = 0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   enq,
  input  logic                   deq,
  input  logic [KEY_W+VAL_W-1:0] kvi,
  output logic [KEY_W+VAL_W-1:0] kvo,
  output logic                   full,
  output logic                   empty,
  output logic                   busy,
  output logic [LEVELS:0]        count
`ifdef HEAP_PQ_ERR_EN
  ,
  output logic                   err
`endif
);
  localparam int c_cap = 2**LEVELS - 1;
  localparam logic [LEVELS:0]   c_cap_cnt = c_cap[LEVELS:0];
  localparam logic [LEVELS:0]   c_one_cnt = 1;
  localparam logic [LEVELS-1:0] c_root    = 1;

  typedef struct packed {
    logic [KEY_W-1:0] key;
    logic [VAL_W-1:0] val;
  } kv_t;

  // Slot 0 is a spare so every LEVELS-bit index stays inside the array.
  kv_t               r_heap [0:c_cap];
  heap_state_t       r_state, w_state_nxt;
  logic [LEVELS:0]   r_count;
  logic [LEVELS-1:0] r_idx;

  logic              w_idle, w_push, w_pop, w_repl;
  logic [LEVELS:0]   w_cnt_inc, w_cnt_dec;
  logic [LEVELS-1:0] w_par, w_left, w_right, w_child;
  logic [LEVELS:0]   w_left_w, w_right_w;
  logic              w_left_ok, w_right_ok, w_right_wins;
  logic              w_up_better, w_down_better, w_down_swap, w_child_leaf;

  assign w_idle    = (r_state == HS_IDLE);
  assign empty     = (r_count == '0);
  assign full      = (r_count == c_cap_cnt);
  assign busy      = !w_idle;
  assign count     = r_count;
  assign kvo       = empty ? '0 : r_heap[c_root];

  // Enq+deq on an empty queue degenerates into a plain enq.
  assign w_push    = w_idle && enq && (!deq || empty) && !full;
  assign w_pop     = w_idle && deq && !enq && !empty;
  assign w_repl    = w_idle && enq && deq && !empty;
  assign w_cnt_inc = r_count + c_one_cnt;
  assign w_cnt_dec = r_count - c_one_cnt;

  assign w_par      = r_idx >> 1;
  assign w_left_w   = {r_idx, 1'b0};
  assign w_right_w  = {r_idx, 1'b1};
  assign w_left_ok  = (w_left_w <= r_count);
  assign w_right_ok = (w_right_w <= r_count);
  assign w_left     = w_left_w[LEVELS-1:0];
  assign w_right    = w_right_w[LEVELS-1:0];
  // Right child wins only when strictly better, so ties go left.
  assign w_child    = (w_right_ok && w_right_wins) ? w_right : w_left;
  assign w_down_swap  = w_left_ok && w_down_better;
  assign w_child_leaf = ({w_child, 1'b0} > r_count);

  heap_cmp #(.KEY_W(KEY_W), .MAX_FIRST(MAX_FIRST)) u_cmp_up (
    .a        (r_heap[r_idx].key),
    .b        (r_heap[w_par].key),
    .a_better (w_up_better)
  );

  heap_cmp #(.KEY_W(KEY_W), .MAX_FIRST(MAX_FIRST)) u_cmp_sib (
    .a        (r_heap[w_right].key),
    .b        (r_heap[w_left].key),
    .a_better (w_right_wins)
  );

  heap_cmp #(.KEY_W(KEY_W), .MAX_FIRST(MAX_FIRST)) u_cmp_down (
    .a        (r_heap[w_child].key),
    .b        (r_heap[r_idx].key),
    .a_better (w_down_better)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= HS_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      HS_IDLE: begin
        if (w_push && (r_count != '0))            w_state_nxt = HS_SIFT_UP;
        else if (w_pop && (w_cnt_dec > c_one_cnt)) w_state_nxt = HS_SIFT_DOWN;
        else if (w_repl && (r_count > c_one_cnt))  w_state_nxt = HS_SIFT_DOWN;
      end
      HS_SIFT_UP: begin
        if (!w_up_better || (w_par == c_root)) w_state_nxt = HS_IDLE;
      end
      HS_SIFT_DOWN: begin
        if (!w_down_swap || w_child_leaf) w_state_nxt = HS_IDLE;
      end
      default: w_state_nxt = HS_IDLE;
    endcase
  end

  // Heap contents are not reset; only count and the walk index are.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
      r_idx   <= '0;
    end else begin
      case (r_state)
        HS_IDLE: begin
          if (w_push) begin
            r_heap[w_cnt_inc[LEVELS-1:0]] <= kvi;
            r_count <= w_cnt_inc;
            r_idx   <= w_cnt_inc[LEVELS-1:0];
          end else if (w_pop) begin
            r_heap[c_root] <= r_heap[r_count[LEVELS-1:0]];
            r_count <= w_cnt_dec;
            r_idx   <= c_root;
          end else if (w_repl) begin
            r_heap[c_root] <= kvi;
            r_idx   <= c_root;
          end
        end
        HS_SIFT_UP: begin
          if (w_up_better) begin
            r_heap[r_idx] <= r_heap[w_par];
            r_heap[w_par] <= r_heap[r_idx];
            r_idx         <= w_par;
          end
        end
        HS_SIFT_DOWN: begin
          if (w_down_swap) begin
            r_heap[r_idx]   <= r_heap[w_child];
            r_heap[w_child] <= r_heap[r_idx];
            r_idx           <= w_child;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef HEAP_PQ_ERR_EN
  logic r_err;
  logic w_bad;
  assign w_bad = (!w_idle && (enq || deq)) ||
                 (w_idle && enq && !deq && full) ||
                 (w_idle && deq && !enq && empty);
  always_ff @(posedge clk) begin
    if (rst)        r_err <= 1'b0;
    else if (w_bad) r_err <= 1'b1;
  end
  assign err = r_err;
`endif
endmodule
`default_nettype wire

// File: tb/tb_heap_pq_param.sv
`default_nettype none
// Testbench for heap_pq_param: directed table, corner sequences, and random
// traffic against a queue-based reference model, for min and max ordering.
module tb_heap_pq_param;
  localparam int KW  = 16;
  localparam int VW  = 16;
  localparam int LV  = 3;
  localparam int CAP = 7;

  logic        clk = 1'b0;
  logic        rst, enq, deq;
  logic [31:0] kvi;
  logic [31:0] kvo_n, kvo_x;
  logic        full_n, full_x, empty_n, empty_x, busy_n, busy_x;
  logic [3:0]  cnt_n, cnt_x;
`ifdef HEAP_PQ_ERR_EN
  logic        err_n, err_x;
`endif

  always #5 clk = ~clk;

  heap_pq_param #(.KEY_W(KW), .VAL_W(VW), .LEVELS(LV), .MAX_FIRST(0)) dut (
    .clk(clk), .rst(rst), .enq(enq), .deq(deq), .kvi(kvi), .kvo(kvo_n),
    .full(full_n), .empty(empty_n), .busy(busy_n), .count(cnt_n)
`ifdef HEAP_PQ_ERR_EN
    , .err(err_n)
`endif
  );

  heap_pq_param #(.KEY_W(KW), .VAL_W(VW), .LEVELS(LV), .MAX_FIRST(1)) dut_max (
    .clk(clk), .rst(rst), .enq(enq), .deq(deq), .kvi(kvi), .kvo(kvo_x),
    .full(full_x), .empty(empty_x), .busy(busy_x), .count(cnt_x)
`ifdef HEAP_PQ_ERR_EN
    , .err(err_x)
`endif
  );

  bit          sel_max;
  logic [31:0] m_kvo;
  logic        m_full, m_empty, m_busy;
  logic [3:0]  m_cnt;
  assign m_kvo   = sel_max ? kvo_x   : kvo_n;
  assign m_full  = sel_max ? full_x  : full_n;
  assign m_empty = sel_max ? empty_x : empty_n;
  assign m_busy  = sel_max ? busy_x  : busy_n;
  assign m_cnt   = sel_max ? cnt_x   : cnt_n;

  int tests = 0;
  int fails = 0;

  function automatic logic [15:0] vof(input logic [15:0] k);
    logic [15:0] t;
    t = k * 16'h9E37;
    return t ^ 16'h5A5A;
  endfunction

  function automatic logic [31:0] kvf(input logic [15:0] k);
    return {k, vof(k)};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; enq = 1'b0; deq = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // Issue one command, return kvo seen in the command cycle and busy length.
  task automatic cmd(input bit e, input bit d, input logic [15:0] k, input bit junk,
                     output logic [31:0] rd, output int bcyc);
    @(negedge clk);
    enq = e; deq = d; kvi = kvf(k);
    #1 rd = m_kvo;
    @(negedge clk);
    enq = 1'b0; deq = 1'b0;
    bcyc = 0;
    while (m_busy && bcyc < 40) begin
      if (junk) begin
        enq = 1'($urandom_range(0, 1));
        deq = 1'($urandom_range(0, 1));
        kvi = $urandom;
      end
      @(negedge clk);
      enq = 1'b0; deq = 1'b0;
      bcyc++;
    end
    if (bcyc >= 40) begin
      tests++; fails++;
      $display("FAIL busy_timeout: busy still high after %0d cycles, required low", bcyc);
    end
  endtask

  typedef struct {
    bit          e;
    bit          d;
    logic [15:0] k;
    bit          chk_rd;
    logic [15:0] rd_key;
    logic [15:0] top;
    int          cnt;
    int          bexp;
    bit          er;
  } vec_t;

  function automatic vec_t mk(input bit e, input bit d, input int k, input bit crd,
                              input int rk, input int top, input int cnt, input int b,
                              input bit er);
    vec_t v;
    v.e = e; v.d = d; v.k = 16'(k); v.chk_rd = crd; v.rd_key = 16'(rk);
    v.top = 16'(top); v.cnt = cnt; v.bexp = b; v.er = er;
    return v;
  endfunction

  logic [31:0] mq[$];

  function automatic int best(input bit mx);
    int b = -1;
    foreach (mq[i]) begin
      if (b < 0) b = i;
      else if (mx ? (mq[i][31:16] > mq[b][31:16]) : (mq[i][31:16] < mq[b][31:16])) b = i;
    end
    return b;
  endfunction

  function automatic int depth_of(input int p);
    int d = 0;
    int q = p;
    while (q > 1) begin q = q >> 1; d++; end
    return d;
  endfunction

  task automatic random_run(input bit mx, input int nops);
    logic [31:0] rd, exp_rd, kv;
    logic [15:0] k;
    int bcyc, bnd, bi, n, r;
    bit e, d;
    sel_max = mx;
    do_reset();
    mq.delete();
    for (int i = 0; i < nops; i++) begin
      r = $urandom_range(0, 9);
      e = (r < 5) || (r >= 8);
      d = (r >= 5);
      k = 16'($urandom_range(0, 31));
      kv = kvf(k);
      n = mq.size();
      bi = best(mx);
      exp_rd = (n > 0) ? mq[bi] : 32'h0;
      cmd(e, d, k, ($urandom_range(0, 3) == 0), rd, bcyc);
      check("rand_rd_kvo", rd, exp_rd);
      if (e && d && n > 0) begin
        mq.delete(bi); mq.push_back(kv); bnd = LV - 1;
      end else if (e && n < CAP) begin
        mq.push_back(kv); bnd = depth_of(n + 1);
      end else if (d && !e && n > 0) begin
        mq.delete(bi); bnd = LV - 1;
      end else begin
        bnd = 0;
      end
      check("rand_count", 32'(m_cnt), mq.size());
      bi = best(mx);
      check("rand_kvo", m_kvo, (mq.size() > 0) ? mq[bi] : 32'h0);
      check("rand_busy_bound", 32'(bcyc <= bnd), 32'd1);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        vt[18];
    logic [31:0] rd;
    int          bcyc;

    rst = 1'b1; enq = 1'b0; deq = 1'b0; kvi = '0; sel_max = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_empty", 32'(empty_n), 1);
    check("rst_full",  32'(full_n),  0);
    check("rst_busy",  32'(busy_n),  0);
    check("rst_count", 32'(cnt_n),   0);
    check("rst_kvo",   kvo_n,        0);
    check("rst_max_empty", 32'(empty_x), 1);
`ifdef HEAP_PQ_ERR_EN
    check("rst_err", 32'(err_n), 0);
`endif
    rst = 1'b0;

    //          e  d  key rd? rdk top cnt busy err
    vt[0]  = mk(1, 0, 5,  0, 0, 5, 1, 0, 0);
    vt[1]  = mk(1, 0, 3,  0, 0, 3, 2, 1, 0);
    vt[2]  = mk(1, 0, 8,  0, 0, 3, 3, 1, 0);
    vt[3]  = mk(1, 0, 1,  0, 0, 1, 4, 2, 0);
    vt[4]  = mk(0, 1, 0,  1, 1, 3, 3, 1, 0);
    vt[5]  = mk(0, 1, 0,  1, 3, 5, 2, 1, 0);
    vt[6]  = mk(0, 1, 0,  1, 5, 8, 1, 0, 0);
    vt[7]  = mk(0, 1, 0,  1, 8, 0, 0, 0, 0);
    vt[8]  = mk(0, 1, 0,  1, 0, 0, 0, 0, 1);
    vt[9]  = mk(1, 0, 7,  0, 0, 7, 1, 0, 1);
    vt[10] = mk(1, 0, 6,  0, 0, 6, 2, 1, 1);
    vt[11] = mk(1, 0, 5,  0, 0, 5, 3, 1, 1);
    vt[12] = mk(1, 0, 4,  0, 0, 4, 4, 2, 1);
    vt[13] = mk(1, 0, 3,  0, 0, 3, 5, 2, 1);
    vt[14] = mk(1, 0, 2,  0, 0, 2, 6, 2, 1);
    vt[15] = mk(1, 0, 1,  0, 0, 1, 7, 2, 1);
    vt[16] = mk(1, 0, 0,  0, 0, 1, 7, 0, 1);
    vt[17] = mk(1, 1, 9,  1, 1, 2, 7, -1, 1);

    for (int i = 0; i < 18; i++) begin
      cmd(vt[i].e, vt[i].d, vt[i].k, 1'b0, rd, bcyc);
      if (vt[i].chk_rd) check("vec_rd_key", 32'(rd[31:16]), 32'(vt[i].rd_key));
      check("vec_kvo",   m_kvo, (vt[i].cnt == 0) ? 32'h0 : kvf(vt[i].top));
      check("vec_count", 32'(m_cnt), vt[i].cnt);
      check("vec_full",  32'(m_full),  32'(vt[i].cnt == CAP));
      check("vec_empty", 32'(m_empty), 32'(vt[i].cnt == 0));
      if (vt[i].bexp >= 0) check("vec_busy_cycles", bcyc, vt[i].bexp);
`ifdef HEAP_PQ_ERR_EN
      check("vec_err", 32'(err_n), 32'(vt[i].er));
`endif
    end

    // Replace-top on {2,4,6}
    do_reset();
    cmd(1, 0, 2, 0, rd, bcyc);
    cmd(1, 0, 4, 0, rd, bcyc);
    cmd(1, 0, 6, 0, rd, bcyc);
    cmd(1, 1, 5, 0, rd, bcyc);
    check("repl_rd", rd, kvf(2));
    check("repl_count", 32'(m_cnt), 3);
    check("repl_top", m_kvo, kvf(4));
    cmd(0, 1, 0, 0, rd, bcyc); check("repl_deq0", rd, kvf(4));
    cmd(0, 1, 0, 0, rd, bcyc); check("repl_deq1", rd, kvf(5));
    cmd(0, 1, 0, 0, rd, bcyc); check("repl_deq2", rd, kvf(6));
    check("repl_empty", 32'(m_empty), 1);

    // Largest-first instance
    sel_max = 1'b1;
    do_reset();
    cmd(1, 0, 5, 0, rd, bcyc);
    cmd(1, 0, 9, 0, rd, bcyc);
    cmd(1, 0, 2, 0, rd, bcyc);
    check("max_top", m_kvo, kvf(9));
    cmd(0, 1, 0, 0, rd, bcyc); check("max_deq0", rd, kvf(9));
    cmd(0, 1, 0, 0, rd, bcyc); check("max_deq1", rd, kvf(5));
    cmd(0, 1, 0, 0, rd, bcyc); check("max_deq2", rd, kvf(2));
    check("max_empty", 32'(m_empty), 1);

    // Reset during the first sift-down cycle
    sel_max = 1'b0;
    do_reset();
    for (int i = 1; i <= CAP; i++) cmd(1, 0, 16'(i * 3), 0, rd, bcyc);
    check("mid_full", 32'(m_full), 1);
    @(negedge clk); deq = 1'b1;
    @(negedge clk); deq = 1'b0;
    check("mid_busy_seen", 32'(m_busy), 1);
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_busy",  32'(m_busy),  0);
    check("mid_rst_count", 32'(m_cnt),   0);
    check("mid_rst_empty", 32'(m_empty), 1);
    rst = 1'b0;
    cmd(1, 0, 4, 0, rd, bcyc);
    check("mid_post_enq", m_kvo, kvf(4));

    random_run(1'b0, 250);
    random_run(1'b1, 150);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/heap_pq_param.md
# heap_pq_param

Parametrised, multi-cycle binary-heap priority queue. It is the successor to the fixed-size heap queue in the pq family, with these generalisations:
- Key width, value width, depth and ordering (min or max first) are all parameters.
- Simultaneous enq+deq performs a replace-top operation.
- A real `busy` handshake covers the sift phases.

It sits behind the same command style as the other pq_pkg queues (enq/deq/kvi/kvo/full/empty/busy), as a drop-in for schedulers that need more than one-cycle shift-register depth.

## Interface
- `KEY_W`, default 16: key width in bits.
- `VAL_W`, default 16: value width in bits.
- `LEVELS`, default 4: heap levels; capacity `CAP = 2**LEVELS - 1`; legal range 2..10.
- `MAX_FIRST`, default 0: 0 selects smallest key first, 1 selects largest key first.
- `clk`  in  1  clock. One clock; all logic on its rising edge.
- `rst`  in  1  reset. Synchronous, active-high.
- `enq`  in  1  enqueue request; sampled only when `busy`=0.
- `deq`  in  1  dequeue request; sampled only when `busy`=0.
- `kvi`  in  KEY_W+VAL_W  key in MSBs, value in LSBs.
- `kvo`  out  KEY_W+VAL_W  top-priority pair; valid when `!empty && !busy`.
- `full`  out  1  count == CAP.
- `empty`  out  1  count == 0.
- `busy`  out  1  sift in progress; commands are ignored.
- `count`  out  LEVELS+1  number of stored items.
- `err`  out  1  sticky error flag; only present with `HEAP_PQ_ERR_EN`.

## Operation
Storage and ordering:
- Heap array `heap[1:CAP]` in registers. Node i has parent i/2 and children 2i and 2i+1.
- "Better" means strictly smaller key (MAX_FIRST=0) or strictly larger key (MAX_FIRST=1).
- Equal keys never swap.
- Values never take part in comparisons.

State machine is `IDLE`, `SIFT_UP`, `SIFT_DOWN`. `busy` = (state != IDLE). Commands in IDLE:
- **Enq only, !full:**
  - Write `heap[count+1]=kvi`, count++, idx=count+1.
  - Go to SIFT_UP if idx>1, else stay in IDLE.
- **Deq only, !empty:**
  - Write `heap[1]=heap[count]`, count--, idx=1.
  - Go to SIFT_DOWN if the new count>1, else stay in IDLE.
- **Enq+deq, !empty (replace, legal even when full):**
  - Write `heap[1]=kvi`; count unchanged; idx=1.
  - Go to SIFT_DOWN if count>1.
- **Enq+deq, empty:** treated as a plain enq.
- **Enq while full (no deq), or deq while empty:** ignored; no state change.

Sift phases:
- **SIFT_UP, one step per cycle:**
  - If `heap[idx]` is better than `heap[idx/2]`: swap them and set idx=idx/2. Go to IDLE if the new idx==1.
  - Otherwise go to IDLE.
- **SIFT_DOWN, one step per cycle:**
  - Pick the best existing child (index <= count). On a tie between children, pick the left one.
  - If that child is better than `heap[idx]`: swap and set idx=child. Go to IDLE if the new idx has no children.
  - Otherwise go to IDLE.

Other rules:
- `kvo` = `heap[1]`, or all zeros when empty.
- A deq consumer reads `kvo` in the same cycle it asserts `deq`.

## Timing
- Reset values: count=0, empty=1, full=0, busy=0, kvo=0, state=IDLE, err=0.
- `rst` overrides everything, including mid-sift. Heap contents become don't-care.
- The command is accepted at edge T. `count`, `full` and `empty` update at T. `busy` is high from T+1 for the duration of the sift.
- Busy cycles:
  - Enq at depth d: at most d cycles.
  - Deq or replace: at most LEVELS-1 cycles.
  - Zero cycles when no sift is needed. This covers enq into an empty queue, deq leaving 0 or 1 items, and replace with count 1.
- A stop decision takes effect on the same edge as the final compare, so `busy` falls on the edge after the last compare cycle.
- Commands presented while `busy`=1 are dropped. The producer must hold them.

## Configuration
- `HEAP_PQ_ERR_EN` defined:
  - The `err` port exists.
  - It is set on enq while full without deq, on deq while empty, or on any enq/deq while busy.
  - It is sticky until `rst`.
- `HEAP_PQ_ERR_EN` not defined: no `err` port; those commands are silently dropped.

## Structure
- pq_pkg holds:
  - Default constants `PQ_KEY_W`, `PQ_VAL_W`, `PQ_LEVELS`.
  - Enum `heap_state_t {HS_IDLE, HS_SIFT_UP, HS_SIFT_DOWN}`.
- The module derives its local packed `kv_t` struct from `KEY_W` and `VAL_W`.
- One sub-module, `heap_cmp`: combinational, parameters KEY_W and MAX_FIRST, inputs key a and key b, output a_better. It is instantiated for the parent compare and the child compare.

## Test plan
All scenarios use LEVELS=3 (CAP=7), MAX_FIRST=0 unless stated, and wait for `busy`=0 between commands.
- **Reset:** assert rst 2 cycles -> empty=1, full=0, busy=0, count=0, kvo=0.
- **Ordering:** enq keys 5,3,8,1 -> kvo key=1, count=4. Four deqs return 1,3,5,8, then empty=1.
- **Full and ignored enq:** enq 7,6,5,4,3,2,1 -> full=1, count=7. The enq of 1 into six items shows busy for exactly 2 cycles. A further enq of 0 is ignored: count=7, kvo key=1, and err=1 with the macro.
- **Replace:** heap {2,4,6}; enq+deq with key 5 -> kvo reads 2 in that cycle; count stays 3. Afterwards kvo=4, and deqs return 4,5,6.
- **Max mode:** MAX_FIRST=1; enq 5,9,2 -> kvo key=9. Deqs return 9,5,2.
- **Reset mid-sift:** full heap; deq, then rst on the first busy cycle -> on the next cycle busy=0, count=0, empty=1. A subsequent enq 4 gives kvo key=4.
